noc_out_arbiter: RTL and testbench
==================================

Name: noc_out_arbiter

Overview:
- Router output stage directly downstream of the per-port 8x18 input queues.
- Arbitrates round-robin among N_IN input queues with wormhole packet locking: a granted port holds the output until its tail flit passes.
- Issues the read strobes to the queues and forwards flits to the output link.
- Output link flow control is credit-based.

Parameters:
- N_IN, 5, number of input queues (N, E, S, W, Local).
- DATA_SIZE, 18, flit width; bits [17:16] are the flit type, bits [15:0] are the payload.
- CREDITS, 8, downstream buffer depth; also the credit counter reset value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- q_empty  in  N_IN  per-queue empty; 1 = no flit readable
- q_data  in  N_IN*DATA_SIZE  flattened queue outputs; queue i occupies bits [i*DATA_SIZE +: DATA_SIZE]; valid the cycle after q_rd[i]
- q_rd  out  N_IN  one-hot read strobe; at most one bit set per cycle
- q_en  out  1  queue enable, tied to 1 outside reset
- credit_in  in  1  one downstream slot freed this cycle
- out_write  out  1  out_data valid this cycle
- out_data  out  DATA_SIZE  forwarded flit, registered

Behaviour:
- Flit types (bits [17:16]):
  - 00 BODY
  - 01 HEAD
  - 10 TAIL
  - 11 SINGLE (head and tail)
- Reset values: state=IDLE, grant=0, rr_ptr=0, credit=CREDITS, q_rd=0, q_en=0, out_write=0, out_data=0.
- Reset mid-packet: the in-flight flit and the lock are dropped, with no output afterwards.
- can_rd(i) = !q_empty[i] && credit!=0.
- The credit counter is clog2(CREDITS+1) bits wide:
  - decrement on a cycle with any q_rd bit set;
  - increment on credit_in;
  - both in the same cycle leaves it unchanged;
  - credit_in at credit==CREDITS is ignored, and an assertion fires.
- State IDLE:
  - winner = first i with can_rd(i), scanning from rr_ptr upward with wrap at N_IN-1 -> 0;
  - on a win: q_rd[winner]=1, grant<=winner, go to WAIT;
  - no win: stay in IDLE.
- State WAIT (a flit from grant is on q_data this cycle):
  - the flit is captured into out_data and out_write=1 the next cycle, i.e. 2-cycle latency from q_rd to out_write;
  - type TAIL or SINGLE: go to IDLE with rr_ptr<=(grant+1) mod N_IN; no read this cycle;
  - type HEAD or BODY, can_rd(grant): q_rd[grant]=1, stay in WAIT (back-to-back, 1 flit/cycle);
  - type HEAD or BODY, !can_rd(grant): go to LOCKED.
- State LOCKED:
  - only grant may be read; other ports are ignored even if non-empty;
  - can_rd(grant): q_rd[grant]=1, go to WAIT; otherwise stay.
- A HEAD arriving inside a locked packet is forwarded as a continuation flit (no re-arbitration).
- Flits are never dropped or duplicated; per-port order is preserved.
- Packets never interleave on out_data.
- Round-robin pointer advances only on packet completion, which gives starvation freedom.

Decomposition:
- noc_pkg holds:
  - flit_type_t enum (BODY/HEAD/TAIL/SINGLE);
  - FLIT_TYPE_MSB/LSB constants;
  - DATA_SIZE default;
  - arb_state_t enum (IDLE/WAIT/LOCKED).
- One natural sub-module, rr_arbiter:
  - parameterised N_IN;
  - inputs are the request vector and rr_ptr;
  - combinational outputs are the one-hot grant and its index.

Test Plan:
- Reset, then all queues empty -> q_rd=0, out_write=0, credit=8 for 20 cycles.
- Port 2 holds HEAD 0x1_00AA, BODY 0x0_00BB, TAIL 0x2_00CC; credits=8 -> q_rd[2] on 3 consecutive cycles; out_data = 0x100AA, 0x000BB, 0x200CC on 3 consecutive cycles starting 2 cycles after the first q_rd; credit=5.
- Ports 0 and 3 both hold 3-flit packets arriving the same cycle -> port 0's packet completes first with no interleave, then port 3; rr_ptr=4 at the end.
- credits=2, no credit_in, port 1 holds a 4-flit packet -> exactly 2 reads, then state LOCKED, q_rd=0. Pulse credit_in once -> exactly 1 more flit out.
- Port 4 empties mid-packet (HEAD, BODY sent) while port 0 is non-empty -> port 0 is not read. Port 4 refills with TAIL -> TAIL forwarded, then port 0 granted.
- Assert rst while in WAIT mid-packet -> next cycle out_write=0, q_rd=0, credit=8, and the arbiter restarts from port 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC router output stage.
package noc_pkg;

    localparam int DATA_SIZE     = 18;
    localparam int FLIT_TYPE_MSB = 17;
    localparam int FLIT_TYPE_LSB = 16;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        LOCKED = 2'b10
    } arb_state_t;

    // A flit that closes a packet releases the output lock.
    function automatic logic is_last(input flit_type_t t);
        return (t == TAIL) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/noc_out_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_IN  = 5,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int off = 0; off < N_IN; off++) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= N_IN) begin
                cand = cand - N_IN;
            end
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Router output stage: round-robin wormhole arbitration over the input
// queues with credit-based flow control toward the downstream link.
module noc_out_arbiter #(
    parameter int N_IN      = 5,
    parameter int DATA_SIZE = 18,
    parameter int CREDITS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN-1:0]           q_empty,
    input  logic [N_IN*DATA_SIZE-1:0] q_data,
    output logic [N_IN-1:0]           q_rd,
    output logic                      q_en,
    input  logic                      credit_in,
    output logic                      out_write,
    output logic [DATA_SIZE-1:0]      out_data
);
    import noc_pkg::*;

    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CRED_W = $clog2(CREDITS + 1);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0]    credit_q, credit_d;
    logic                 out_write_q, out_write_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;

    logic [N_IN-1:0]      can_rd;
    logic [N_IN-1:0]      rd_vec;
    logic [N_IN-1:0]      arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_vld;
    logic [DATA_SIZE-1:0] cur_flit;
    flit_type_t           cur_type;

    rr_arbiter #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (can_rd),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Readability per port and the flit currently presented by the granted queue.
    always_comb begin
        cur_flit = '0;
        for (int i = 0; i < N_IN; i++) begin
            can_rd[i] = !q_empty[i] && (credit_q != '0);
            if (grant_q == IDX_W'(i)) begin
                cur_flit = q_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
        cur_type = flit_type_t'(cur_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
    end

    // Arbitration FSM: pick a port in IDLE, stream it in WAIT, park in LOCKED.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        rd_vec   = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    rd_vec  = arb_gnt;
                    grant_d = arb_idx;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (is_last(cur_type)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(N_IN - 1)) ? '0 : grant_q + IDX_W'(1);
                end else if (can_rd[grant_q]) begin
                    rd_vec[grant_q] = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (can_rd[grant_q]) begin
                    rd_vec[grant_q] = 1'b1;
                    state_d         = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit bookkeeping and the registered output flit.
    always_comb begin
        credit_d = credit_q;
        unique case ({|rd_vec, credit_in && (credit_q != CRED_W'(CREDITS))})
            2'b10:   credit_d = credit_q - CRED_W'(1);
            2'b01:   credit_d = credit_q + CRED_W'(1);
            default: credit_d = credit_q;
        endcase
        out_write_d = (state_q == WAIT);
        out_data_d  = (state_q == WAIT) ? cur_flit : out_data_q;
    end

    // State register; reset drops any lock and any flit in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            credit_q    <= CRED_W'(CREDITS);
            out_write_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
            out_write_q <= out_write_d;
            out_data_q  <= out_data_d;
        end
    end

    // A credit returned while the counter is already full indicates a downstream bug.
    always_ff @(posedge clk) begin
        if (!rst && credit_in) begin
            assert (credit_q != CRED_W'(CREDITS));
        end
    end

    assign q_rd      = rst ? '0 : rd_vec;
    assign q_en      = !rst;
    assign out_write = out_write_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Bench for noc_out_arbiter: directed scenarios followed by randomized
// packet rounds checked against a packet-level round-robin model.
module tb_noc_out_arbiter;
    import noc_pkg::*;

    localparam int N  = 5;
    localparam int DW = 18;
    localparam int CR = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    q_empty;
    logic [N*DW-1:0] q_data;
    logic [N-1:0]    q_rd;
    logic            q_en;
    logic            credit_in;
    logic            out_write;
    logic [DW-1:0]   out_data;

    always #5 clk = ~clk;

    noc_out_arbiter #(.N_IN(N), .DATA_SIZE(DW), .CREDITS(CR)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_rd      (q_rd),
        .q_en      (q_en),
        .credit_in (credit_in),
        .out_write (out_write),
        .out_data  (out_data)
    );

    // Input queue contents and their registered read ports.
    logic [DW-1:0] fifo [N][$];
    logic [DW-1:0] qd [N];

    always_comb begin
        for (int i = 0; i < N; i++) q_data[i*DW +: DW] = qd[i];
    end

    int            total = 0;
    int            bad   = 0;
    int            down_cnt;
    bit            auto_cr;
    int            rd_cnt [N];
    logic [DW-1:0] out_log [$];

    logic [N-1:0]  rd_s, emp_s;
    logic          ow_s, qen_s;
    logic [DW-1:0] od_s;
    logic [3:0]    cred_s;
    logic [1:0]    st_s;
    logic [2:0]    ptr_s;

    logic [N-1:0]  e_rd [6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    logic          e_ow [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] e_od [6] = '{18'h0, 18'h0, 18'h100AA, 18'h000BB, 18'h200CC, 18'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) q_empty[i] = (fifo[i].size() == 0);
    endtask

    task automatic push(input int p, input logic [DW-1:0] f);
        fifo[p].push_back(f);
        refresh();
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) begin
            fifo[i].delete();
            qd[i] = '0;
        end
        refresh();
    endtask

    task automatic clear_logs();
        out_log.delete();
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
    endtask

    // One clock: sample outputs at negedge, then model the queues and downstream after posedge.
    task automatic step();
        @(negedge clk);
        rd_s   = q_rd;
        emp_s  = q_empty;
        ow_s   = out_write;
        od_s   = out_data;
        qen_s  = q_en;
        cred_s = dut.credit_q;
        st_s   = dut.state_q;
        ptr_s  = dut.rr_ptr_q;
        chk("rd_onehot0", 32'($onehot0(rd_s)), 32'd1);
        chk("rd_of_empty", 32'(rd_s & emp_s), 32'd0);
        if (ow_s === 1'b1) begin
            out_log.push_back(od_s);
            down_cnt++;
        end
        if (credit_in && down_cnt > 0) down_cnt--;
        for (int i = 0; i < N; i++) if (rd_s[i]) rd_cnt[i]++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i] && fifo[i].size() > 0) qd[i] = fifo[i].pop_front();
        end
        refresh();
        credit_in = (auto_cr && down_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic do_reset();
        clear_fifos();
        rst = 1'b1;
        step();
        step();
        rst      = 1'b0;
        down_cnt = 0;
        clear_logs();
    endtask

    task automatic wait_out(input int n, input int budget);
        int k;
        k = 0;
        while (out_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_out_count", 32'(out_log.size()), 32'(n));
    endtask

    // Reference model: per-port packet lists and an abstract round-robin pointer.
    int            plen  [N][$];
    logic [DW-1:0] mflit [N][$];
    logic [DW-1:0] exp_q [$];
    int            model_ptr;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        credit_in = 1'b0;
        auto_cr   = 1'b0;
        down_cnt  = 0;
        clear_fifos();
        clear_logs();

        // Reset values
        step();
        step();
        step();
        chk("rst_out_write", 32'(ow_s), 32'd0);
        chk("rst_out_data", 32'(od_s), 32'd0);
        chk("rst_q_rd", 32'(rd_s), 32'd0);
        chk("rst_q_en", 32'(qen_s), 32'd0);
        chk("rst_credit", 32'(cred_s), 32'(CR));
        chk("rst_state", 32'(st_s), 32'(IDLE));
        chk("rst_rr_ptr", 32'(ptr_s), 32'd0);
        rst = 1'b0;
        clear_logs();

        // All queues empty: nothing happens
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_q_rd", 32'(rd_s), 32'd0);
            chk("idle_out_write", 32'(ow_s), 32'd0);
            chk("idle_credit", 32'(cred_s), 32'(CR));
            chk("idle_q_en", 32'(qen_s), 32'd1);
        end

        // Single 3-flit packet on port 2, exact cycle timing
        push(2, 18'h100AA);
        push(2, 18'h000BB);
        push(2, 18'h200CC);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("p2_q_rd", 32'(rd_s), 32'(e_rd[c]));
            chk("p2_out_write", 32'(ow_s), 32'(e_ow[c]));
            if (e_ow[c]) chk("p2_out_data", 32'(od_s), 32'(e_od[c]));
        end
        chk("p2_credit", 32'(cred_s), 32'd5);
        chk("p2_rr_ptr", 32'(ptr_s), 32'd3);

        // Ports 0 and 3 contend; port 0 first, no interleave
        do_reset();
        push(0, 18'h10001); push(0, 18'h00002); push(0, 18'h20003);
        push(3, 18'h10031); push(3, 18'h00032); push(3, 18'h20033);
        wait_out(6, 40);
        repeat (5) step();
        chk("rr_count", 32'(out_log.size()), 32'd6);
        if (out_log.size() == 6) begin
            chk("rr_f0", 32'(out_log[0]), 32'h10001);
            chk("rr_f1", 32'(out_log[1]), 32'h00002);
            chk("rr_f2", 32'(out_log[2]), 32'h20003);
            chk("rr_f3", 32'(out_log[3]), 32'h10031);
            chk("rr_f4", 32'(out_log[4]), 32'h00032);
            chk("rr_f5", 32'(out_log[5]), 32'h20033);
        end
        chk("rr_ptr_end", 32'(ptr_s), 32'd4);
        chk("rr_credit", 32'(cred_s), 32'd2);

        // Two credits left, 4-flit packet on port 1: stalls in LOCKED
        clear_logs();
        push(1, 18'h10011); push(1, 18'h00012); push(1, 18'h00013); push(1, 18'h20014);
        repeat (10) step();
        chk("cr_reads", 32'(rd_cnt[1]), 32'd2);
        chk("cr_outs", 32'(out_log.size()), 32'd2);
        chk("cr_state", 32'(st_s), 32'(LOCKED));
        chk("cr_q_rd", 32'(rd_s), 32'd0);
        chk("cr_credit", 32'(cred_s), 32'd0);
        credit_in = 1'b1;
        step();
        repeat (9) step();
        chk("cr1_reads", 32'(rd_cnt[1]), 32'd3);
        chk("cr1_outs", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) chk("cr1_flit", 32'(out_log[2]), 32'h00013);
        chk("cr1_state", 32'(st_s), 32'(LOCKED));

        // Port 4 runs dry mid-packet while port 0 waits
        do_reset();
        push(4, 18'h14441);
        push(4, 18'h04442);
        step();
        chk("lk_first_rd", 32'(rd_s), 32'h10);
        push(0, 18'h10001);
        push(0, 18'h20002);
        repeat (10) step();
        chk("lk_p0_reads", 32'(rd_cnt[0]), 32'd0);
        chk("lk_state", 32'(st_s), 32'(LOCKED));
        chk("lk_outs", 32'(out_log.size()), 32'd2);
        push(4, 18'h24443);
        wait_out(5, 40);
        repeat (3) step();
        if (out_log.size() == 5) begin
            chk("lk_f2", 32'(out_log[2]), 32'h24443);
            chk("lk_f3", 32'(out_log[3]), 32'h10001);
            chk("lk_f4", 32'(out_log[4]), 32'h20002);
        end
        chk("lk_p0_reads_after", 32'(rd_cnt[0]), 32'd2);

        // Reset in WAIT mid-packet
        do_reset();
        push(1, 18'h31111);
        wait_out(1, 20);
        repeat (2) step();
        chk("mr_ptr", 32'(ptr_s), 32'd2);
        clear_logs();
        push(3, 18'h13331); push(3, 18'h03332); push(3, 18'h03333); push(3, 18'h23334);
        push(0, 18'h10001); push(0, 18'h20002);
        step();
        chk("mr_grant3", 32'(rd_s), 32'h08);
        rst = 1'b1;
        step();
        chk("mr_rd_in_rst", 32'(rd_s), 32'd0);
        rst      = 1'b0;
        down_cnt = 0;
        step();
        chk("mr_ow_after", 32'(ow_s), 32'd0);
        chk("mr_credit_after", 32'(cred_s), 32'(CR));
        chk("mr_restart_p0", 32'(rd_s), 32'h01);
        step();
        chk("mr_no_stale_out", 32'(ow_s), 32'd0);
        wait_out(2, 30);
        if (out_log.size() >= 2) begin
            chk("mr_f0", 32'(out_log[0]), 32'h10001);
            chk("mr_f1", 32'(out_log[1]), 32'h20002);
        end

        // Randomized rounds against the packet-level model
        do_reset();
        model_ptr = 0;
        auto_cr   = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int found, len;
            clear_logs();
            exp_q.delete();
            for (int p = 0; p < N; p++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int k = 0; k < npk; k++) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        logic [1:0]    ty;
                        logic [DW-1:0] f;
                        ty = (len == 1) ? 2'b11 : (j == 0) ? 2'b01 : (j == len - 1) ? 2'b10 : 2'b00;
                        f  = {ty, 16'($urandom)};
                        push(p, f);
                        mflit[p].push_back(f);
                    end
                    plen[p].push_back(len);
                end
            end
            found = 0;
            while (found >= 0) begin
                found = -1;
                for (int off = 0; off < N; off++) begin
                    int c;
                    c = (model_ptr + off) % N;
                    if (found < 0 && plen[c].size() > 0) found = c;
                end
                if (found >= 0) begin
                    len = plen[found].pop_front();
                    for (int j = 0; j < len; j++) exp_q.push_back(mflit[found].pop_front());
                    model_ptr = (found + 1) % N;
                end
            end
            wait_out(exp_q.size(), 800);
            repeat (5) step();
            chk("rnd_count", 32'(out_log.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < out_log.size(); k++) begin
                chk($sformatf("rnd_r%0d_f%0d", r, k), 32'(out_log[k]), 32'(exp_q[k]));
            end
            chk("rnd_ptr", 32'(ptr_s), 32'(model_ptr));
        end

        // Return all outstanding credits
        begin
            int k;
            k = 0;
            while (down_cnt > 0 && k < 400) begin
                step();
                k++;
            end
        end
        chk("drain_down_cnt", 32'(down_cnt), 32'd0);
        auto_cr = 1'b0;
        repeat (3) step();
        chk("final_credit", 32'(cred_s), 32'(CR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
